// File: rtl/wavetable_osc.sv
// rtl/wavetable_osc.sv - wavetable oscillator: phase accumulator, table read, optional linear interpolation
//
// Optional feature macro: WAVETABLE_OSC_INTERP_EN
//   defined   : two table reads (idx, idx+1) and linear interpolation, tick-to-valid latency 4
//   undefined : single read, truncated-phase lookup, tick-to-valid latency 3
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   sample_tick  in   one-cycle request for a new sample
//   gate         in   voice on (1) / silent (0), sampled at accepted tick
//   phase_inc    in   [PHASE_W] unsigned phase step per accepted tick
//   ram_addr     out  [9] wavetable read address
//   ram_re       out  wavetable read enable
//   ram_ce       out  wavetable chip enable (mirrors ram_re)
//   ram_rdata    in   [16] offset-binary table data, valid the cycle after ram_re
//   sample       out  [16] signed two's-complement sample, registered
//   sample_valid out  one-cycle strobe when sample updates
//   busy         out  high while not idle
//   overrun      out  sticky: tick arrived while busy

module wavetable_osc #(
    parameter int PHASE_W = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sample_tick,
    input  logic               gate,
    input  logic [PHASE_W-1:0] phase_inc,
    output logic [8:0]         ram_addr,
    output logic               ram_re,
    output logic               ram_ce,
    input  logic [15:0]        ram_rdata,
    output logic [15:0]        sample,
    output logic               sample_valid,
    output logic               busy,
    output logic               overrun
);

`ifdef WAVETABLE_OSC_INTERP_EN
    localparam int FW = PHASE_W - 9;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        RD1  = 3'd2,
        CAP  = 3'd3,
        CALC = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD0  = 2'd1,
        CAP  = 2'd2,
        CALC = 2'd3
    } state_t;
`endif

    state_t             state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [8:0]         idx_q, idx_d;
    logic [15:0]        s0_q, s0_d;
    logic [15:0]        sample_q, sample_d;
    logic               valid_q, valid_d;
    logic               overrun_q, overrun_d;
    logic [15:0]        y;

`ifdef WAVETABLE_OSC_INTERP_EN
    logic [FW-1:0]           frac_q, frac_d;
    logic [15:0]             s1_q, s1_d;
    logic signed [16:0]      diff;
    logic signed [FW:0]      frac_s;
    logic signed [PHASE_W+8:0] prod;
    logic signed [PHASE_W+8:0] prod_sh;

    // Offset-binary samples are compared as unsigned, so the difference
    // needs the extra sign bit; frac is zero-extended to stay positive.
    always_comb begin
        diff    = $signed({1'b0, s1_q}) - $signed({1'b0, s0_q});
        frac_s  = $signed({1'b0, frac_q});
        prod    = (PHASE_W+9)'(diff) * (PHASE_W+9)'(frac_s);
        prod_sh = prod >>> FW;
        y       = s0_q + prod_sh[15:0];
    end
`else
    always_comb begin
        y = s0_q;
    end
`endif

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        idx_d     = idx_q;
        s0_d      = s0_q;
        sample_d  = sample_q;
        valid_d   = 1'b0;
        overrun_d = overrun_q;
        ram_re    = 1'b0;
        ram_addr  = 9'd0;
`ifdef WAVETABLE_OSC_INTERP_EN
        frac_d    = frac_q;
        s1_d      = s1_q;
`endif

        // Any tick outside IDLE (including CALC) is dropped and flagged.
        if (sample_tick && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (sample_tick) begin
                    if (gate) begin
                        idx_d   = phase_q[PHASE_W-1 -: 9];
`ifdef WAVETABLE_OSC_INTERP_EN
                        frac_d  = phase_q[PHASE_W-10:0];
`endif
                        phase_d = phase_q + phase_inc;
                        state_d = RD0;
                    end else begin
                        phase_d  = '0;
                        sample_d = 16'h0000;
                        valid_d  = 1'b1;
                    end
                end
            end
            RD0: begin
                ram_re   = 1'b1;
                ram_addr = idx_q;
`ifdef WAVETABLE_OSC_INTERP_EN
                state_d  = RD1;
`else
                state_d  = CAP;
`endif
            end
`ifdef WAVETABLE_OSC_INTERP_EN
            RD1: begin
                ram_re   = 1'b1;
                ram_addr = idx_q + 9'd1;
                s0_d     = ram_rdata;
                state_d  = CAP;
            end
`endif
            CAP: begin
`ifdef WAVETABLE_OSC_INTERP_EN
                s1_d    = ram_rdata;
`else
                s0_d    = ram_rdata;
`endif
                state_d = CALC;
            end
            CALC: begin
                sample_d = y ^ 16'h8000;
                valid_d  = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            idx_q     <= '0;
            s0_q      <= '0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
`ifdef WAVETABLE_OSC_INTERP_EN
            frac_q    <= '0;
            s1_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            idx_q     <= idx_d;
            s0_q      <= s0_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
`ifdef WAVETABLE_OSC_INTERP_EN
            frac_q    <= frac_d;
            s1_q      <= s1_d;
`endif
        end
    end

    assign ram_ce       = ram_re;
    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign busy         = (state_q != IDLE);
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_wavetable_osc.sv
// tb/tb_wavetable_osc.sv - self-checking bench for wavetable_osc
module tb_wavetable_osc;
    localparam int PW = 24;
`ifdef WAVETABLE_OSC_INTERP_EN
    localparam int LAT    = 4;
    localparam bit INTERP = 1'b1;
`else
    localparam int LAT    = 3;
    localparam bit INTERP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sample_tick;
    logic          gate;
    logic [PW-1:0] phase_inc;
    logic [8:0]    ram_addr;
    logic          ram_re;
    logic          ram_ce;
    logic [15:0]   ram_rdata;
    logic [15:0]   sample;
    logic          sample_valid;
    logic          busy;
    logic          overrun;

    always #5 clk = ~clk;

    wavetable_osc #(.PHASE_W(PW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_tick  (sample_tick),
        .gate         (gate),
        .phase_inc    (phase_inc),
        .ram_addr     (ram_addr),
        .ram_re       (ram_re),
        .ram_ce       (ram_ce),
        .ram_rdata    (ram_rdata),
        .sample       (sample),
        .sample_valid (sample_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    logic [15:0] mem [512];
    always @(posedge clk) begin
        if (ram_re) ram_rdata <= mem[ram_addr];
    end

    int tests = 0;
    int fails = 0;
    logic [PW-1:0] ph_m;

    typedef struct {
        logic          g;
        logic [PW-1:0] inc;
        int            exp_addr;
        logic [15:0]   exp_s;
    } vec_t;
    vec_t vt[5];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] model_y(input int idx, input int fr);
        longint s0 = longint'(mem[idx]);
        longint s1 = longint'(mem[(idx + 1) % 512]);
        longint q  = 0;
        if (INTERP) q = ((s1 - s0) * longint'(fr)) >>> (PW - 9);
        return 16'(s0 + q) ^ 16'h8000;
    endfunction

    task automatic do_tick(input logic g, input logic [PW-1:0] inc, input int hold, input bit flip,
                           output int a0, output int a1, output logic [15:0] s);
        int ea[$];
        int ga[$];
        logic [15:0] es;
        int ecyc;
        int nv = 0;
        int vcyc = -1;
        int cebad = 0;
        int idx, fr;
        s  = '0;
        a0 = -1;
        a1 = -1;
        if (g) begin
            idx  = int'(ph_m[PW-1 -: 9]);
            fr   = int'(ph_m[PW-10:0]);
            ph_m = ph_m + inc;
            ea.push_back(idx);
            if (INTERP) ea.push_back((idx + 1) % 512);
            es   = model_y(idx, fr);
            ecyc = LAT + 1;
        end else begin
            ph_m = '0;
            es   = 16'h0000;
            ecyc = 1;
        end
        gate = g;
        phase_inc = inc;
        sample_tick = 1'b1;
        for (int i = 1; i <= LAT + 3; i++) begin
            @(negedge clk);
            if (i == hold) sample_tick = 1'b0;
            if (flip && i == 2) gate = ~g;
            if (ram_re) ga.push_back(int'(ram_addr));
            if (ram_ce !== ram_re) cebad++;
            if (sample_valid) begin
                nv++;
                vcyc = i;
                s = sample;
            end
        end
        chk("valid_count", nv, 1);
        chk("valid_latency", vcyc, ecyc);
        chk("sample", 32'(s), 32'(es));
        chk("read_count", ga.size(), ea.size());
        foreach (ea[j]) if (j < ga.size()) chk("read_addr", ga[j], ea[j]);
        chk("ce_eq_re", cebad, 0);
        chk("busy_end", 32'(busy), 0);
        if (ga.size() > 0) a0 = ga[0];
        if (ga.size() > 1) a1 = ga[1];
    endtask

    initial begin
        int a0, a1;
        logic [15:0] s;
        logic [15:0] exp_interp;

        for (int i = 0; i < 512; i++) mem[i] = 16'($urandom);
        mem[0]  = 16'h8000;
        mem[1]  = 16'h1234;
        mem[2]  = 16'hFFFF;
        mem[10] = 16'h4000;
        mem[11] = 16'h6000;

        vt[0] = '{1'b1, 24'h008000, 0,  16'h0000};
        vt[1] = '{1'b1, 24'h008000, 1,  16'h9234};
        vt[2] = '{1'b1, 24'h008000, 2,  16'h7FFF};
        vt[3] = '{1'b0, 24'h008000, -1, 16'h0000};
        vt[4] = '{1'b1, 24'h008000, 0,  16'h0000};

        rst_n = 1'b0;
        sample_tick = 1'b0;
        gate = 1'b0;
        phase_inc = '0;
        ph_m = '0;
        repeat (2) @(negedge clk);
        chk("reset_state", 32'({ram_re, ram_ce, ram_addr, sample, sample_valid, busy, overrun}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // stepping and gate-off table
        foreach (vt[k]) begin
            do_tick(vt[k].g, vt[k].inc, 1, 1'b0, a0, a1, s);
            chk("tbl_addr", a0, vt[k].exp_addr);
            chk("tbl_sample", 32'(s), 32'(vt[k].exp_s));
        end

        // interpolation: idx 10, frac 0x4000
        do_tick(1'b0, '0, 1, 1'b0, a0, a1, s);
        do_tick(1'b1, 24'h054000, 1, 1'b0, a0, a1, s);
        do_tick(1'b1, 24'h000000, 1, 1'b0, a0, a1, s);
        exp_interp = INTERP ? 16'hD000 : 16'hC000;
        chk("interp_sample", 32'(s), 32'(exp_interp));
        chk("interp_addr0", a0, 10);

        // wrap: idx 511 then 0, phase FFFFFF+1 -> 0
        do_tick(1'b0, '0, 1, 1'b0, a0, a1, s);
        do_tick(1'b1, 24'hFFFFFF, 1, 1'b0, a0, a1, s);
        do_tick(1'b1, 24'h000001, 1, 1'b0, a0, a1, s);
        chk("wrap_addr0", a0, 511);
        if (INTERP) chk("wrap_addr1", a1, 0);
        do_tick(1'b1, 24'h000000, 1, 1'b0, a0, a1, s);
        chk("wrap_phase_zero", a0, 0);

        // overrun: tick held for a second cycle while busy
        chk("overrun_before", 32'(overrun), 0);
        do_tick(1'b1, 24'h0A3000, 2, 1'b0, a0, a1, s);
        chk("overrun_set", 32'(overrun), 1);
        do_tick(1'b1, 24'h001000, 1, 1'b0, a0, a1, s);
        chk("overrun_sticky", 32'(overrun), 1);

        // reset asserted mid-RD0
        gate = 1'b1;
        phase_inc = 24'h123456;
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        chk("rd0_before_reset", 32'(ram_re), 1);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_rd0", 32'({ram_re, ram_ce, ram_addr, sample, sample_valid, busy, overrun}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        ph_m = '0;
        @(negedge clk);
        do_tick(1'b1, 24'h008000, 1, 1'b0, a0, a1, s);
        chk("restart_addr", a0, 0);
        chk("restart_sample", 32'(s), 32'(16'h0000));
        chk("restart_overrun", 32'(overrun), 0);

        // randomized ticks, occasional silent ticks and mid-operation gate flips
        for (int n = 0; n < 40; n++) begin
            do_tick($urandom_range(0, 5) != 0, PW'($urandom), 1, $urandom_range(0, 3) == 0, a0, a1, s);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/wavetable_osc.md
WAVETABLE_OSC -- requirements
Module: wavetable_osc

Interface
REQ-001 SHALL have parameter PHASE_W, default 24, phase accumulator width (min 10); index = phase[PHASE_W-1 -: 9], frac = phase[PHASE_W-10:0].
REQ-002 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port sample_tick  input  1  one-cycle request for a new output sample.
REQ-005 SHALL have port gate  input  1  voice on (1) / silent (0).
REQ-006 SHALL have port phase_inc  input  PHASE_W  unsigned phase step per accepted tick.
REQ-007 SHALL have port ram_addr  output  9  wavetable read address.
REQ-008 SHALL have port ram_re  output  1  wavetable read enable.
REQ-009 SHALL have port ram_ce  output  1  wavetable chip enable, equal to ram_re.
REQ-010 SHALL have port ram_rdata  input  16  wavetable data, offset-binary, valid one clock after the ram_re cycle.
REQ-011 SHALL have port sample  output  16  signed two's-complement sample, registered.
REQ-012 SHALL have port sample_valid  output  1  one-cycle strobe when sample updates.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-014 SHALL have port overrun  output  1  sticky flag, tick arrived while busy.

Function
REQ-015 SHALL implement states IDLE, RD0, RD1, CAP, CALC; RD1 exists only with interpolation compiled in.
REQ-016 SHALL, in IDLE with sample_tick=1 and gate=1, latch idx/frac from current phase, update phase <= phase + phase_inc (mod 2^PHASE_W), go to RD0.
REQ-017 SHALL, in IDLE with sample_tick=1 and gate=0, clear phase to 0, load sample=16'h0000, pulse sample_valid next cycle, issue no RAM read, stay IDLE.
REQ-018 SHALL drive ram_re=ram_ce=1, ram_addr=idx in RD0; ram_re=ram_ce=1, ram_addr=(idx+1) mod 512 in RD1; ram_re=ram_ce=0 and ram_addr=0 elsewhere.
REQ-019 SHALL transition RD0->RD1 (interp) or RD0->CAP (no interp); RD1->CAP capturing s0=ram_rdata; CAP->CALC capturing s1 (interp) or s0 (no interp); CALC->IDLE writing sample.
REQ-020 SHALL compute, in CALC with interpolation, y = s0 + (((s1 - s0) as signed 17-bit) * frac) >>> (PHASE_W-9), truncated to 16 bits; without interpolation y = s0.
REQ-021 SHALL output sample = y XOR 16'h8000 (offset-binary to two's complement).
REQ-022 SHALL give latency tick-edge k -> sample_valid high in the cycle after edge k+4 (interp) or k+3 (no interp).
REQ-023 SHALL ignore sample_tick while busy=1 (no phase update, no extra read) and set overrun=1 until reset.
REQ-024 SHALL let a gate change mid-operation take effect only at the next accepted tick; the current read completes.
REQ-025 SHALL accept a tick in the same cycle that CALC returns to IDLE only on the following cycle (no back-to-back acceptance in CALC).

Reset
REQ-026 SHALL, on rst_n=0 at any time including mid-read, force state IDLE, phase=0, idx=0, frac=0, s0=s1=0, sample=16'h0000, sample_valid=0, busy=0, overrun=0, ram_re=ram_ce=0, ram_addr=0.
REQ-027 SHALL resume normal operation on the first rising clk edge after rst_n deasserts.

Configuration
REQ-028 SHALL, when macro WAVETABLE_OSC_INTERP_EN is defined, include state RD1, the second read and linear interpolation (latency 4).
REQ-029 SHALL, when WAVETABLE_OSC_INTERP_EN is undefined, omit RD1/s1/multiplier, output truncated-phase table lookup (latency 3); ports unchanged.

Verification
REQ-030 SHALL check reset: assert rst_n=0 mid-RD0 -> all outputs 0, busy=0, next tick restarts cleanly.
REQ-031 SHALL check stepping: phase_inc=24'h008000, gate=1, three ticks -> ram_addr 0,1,2; non-interp sample = ram[n]^16'h8000 (ram=16'h8000 -> 16'h0000).
REQ-032 SHALL check interpolation: s0=16'h4000, s1=16'h6000, frac=15'h4000 -> y=16'h5000, sample=16'hD000, valid 4 cycles after tick.
REQ-033 SHALL check wrap: idx=511 with interp -> ram_addr 511 then 0; phase 24'hFFFFFF+1 wraps to 0.
REQ-034 SHALL check overrun: second tick 1 cycle after first -> ignored, one sample_valid only, overrun=1 sticky.
REQ-035 SHALL check gate: tick with gate=0 -> no ram_re, sample=16'h0000, sample_valid pulse, phase=0.
